// File: rtl/frame_reader_master_if.sv
// rtl/frame_reader_master_if.sv - Avalon-MM read port and pixel FIFO write port bundle
//
// master modport (frame reader side):
//   out: avm_read, avm_address, avm_byteenable, fifo_wr_en, fifo_data
//   in : avm_waitrequest, avm_readdatavalid, avm_readdata, fifo_level
// slave modport is the mirror image (SDRAM controller + pixel FIFO side).
interface frame_reader_master_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int LEVEL_W = 10
) ();
  logic                  avm_read;
  logic [ADDR_W-1:0]     avm_address;
  logic [DATA_W/8-1:0]   avm_byteenable;
  logic                  avm_waitrequest;
  logic                  avm_readdatavalid;
  logic [DATA_W-1:0]     avm_readdata;
  logic [LEVEL_W-1:0]    fifo_level;
  logic                  fifo_wr_en;
  logic [DATA_W-1:0]     fifo_data;

  modport master (
    output avm_read, avm_address, avm_byteenable, fifo_wr_en, fifo_data,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata, fifo_level
  );

  modport slave (
    input  avm_read, avm_address, avm_byteenable, fifo_wr_en, fifo_data,
    output avm_waitrequest, avm_readdatavalid, avm_readdata, fifo_level
  );
endinterface

// File: rtl/frame_reader_master.sv
// rtl/frame_reader_master.sv - pipelined Avalon-MM read master streaming one frame per pass into the pixel FIFO
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   enable_i       level; high keeps reading frames back to back
//   frame_base_i   frame start address, sampled when a frame starts
//   bus            frame_reader_master_if.master (Avalon read port + FIFO write port)
//   frame_start_o  one-cycle pulse when the frame base is latched
//   frame_done_o   one-cycle pulse with the last FIFO write of a frame
//   busy_o         high whenever not idle
module frame_reader_master #(
  parameter int ADDR_W          = 30,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_FRAME = 307200,
  parameter int ADDR_STRIDE     = 1,
  parameter int MAX_PENDING     = 4,
  parameter int FIFO_DEPTH      = 512,
  parameter int LEVEL_W         = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [ADDR_W-1:0]   frame_base_i,
  frame_reader_master_if.master bus,
  output logic                frame_start_o,
  output logic                frame_done_o,
  output logic                busy_o
);
  localparam int ISS_W  = $clog2(WORDS_PER_FRAME + 1);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [ISS_W-1:0]  ISS_LAST = ISS_W'(WORDS_PER_FRAME);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ISS_W-1:0]    issued_q, issued_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic                avm_read_q;
  logic                fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_W-1:0]   fifo_data_q;
  logic                frame_start_q, frame_done_q;
  logic [LEVEL_W-1:0]  level;
  logic                accept, ret, credit_ok, can_issue;

  assign level = bus.fifo_level;

  // Everything below is evaluated on post-update counts so a request can be
  // re-issued in the cycle right after the previous one was accepted.
  always_comb begin
    accept       = avm_read_q & ~bus.avm_waitrequest;
    // A return with nothing outstanding belongs to a read issued before reset.
    ret          = bus.avm_readdatavalid & (pending_q != '0);
    fifo_wr_en_d = ret;
    addr_d       = accept ? addr_q + ADDR_W'(ADDR_STRIDE) : addr_q;
    issued_d     = issued_q + ISS_W'(accept);
    pending_d    = pending_q;
    if (accept && !ret) begin
      pending_d = pending_q + PEND_W'(1);
    end else if (!accept && ret) begin
      pending_d = pending_q - PEND_W'(1);
    end
    // Reserve room for every word already stored, in flight or about to be
    // written, plus the new request, so the FIFO can never overflow.
    credit_ok = (32'(level) + 32'(pending_d) + 32'(fifo_wr_en_d) + 32'd1) < 32'(FIFO_DEPTH);
    can_issue = (issued_d < ISS_LAST) && (pending_d < PEND_MAX) && credit_ok;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      issued_q      <= '0;
      pending_q     <= '0;
      avm_read_q    <= 1'b0;
      fifo_wr_en_q  <= 1'b0;
      fifo_data_q   <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      fifo_wr_en_q  <= fifo_wr_en_d;
      if (ret) begin
        fifo_data_q <= bus.avm_readdata;
      end
      addr_q    <= addr_d;
      issued_q  <= issued_d;
      pending_q <= pending_d;

      case (state_q)
        IDLE: begin
          avm_read_q <= 1'b0;
          if (enable_i) begin
            state_q       <= ISSUE;
            addr_q        <= frame_base_i;
            issued_q      <= '0;
            frame_start_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (issued_d == ISS_LAST) begin
            state_q    <= DRAIN;
            avm_read_q <= 1'b0;
          end else if (avm_read_q && bus.avm_waitrequest) begin
            // Stalled request stays put; credits are not re-checked.
            avm_read_q <= 1'b1;
          end else begin
            avm_read_q <= can_issue;
          end
        end
        DRAIN: begin
          avm_read_q <= 1'b0;
          // pending reaches zero on the edge that launches the final FIFO write,
          // so frame_done lines up with that write.
          if (pending_d == '0) begin
            frame_done_q <= 1'b1;
            if (enable_i) begin
              state_q       <= ISSUE;
              addr_q        <= frame_base_i;
              issued_q      <= '0;
              frame_start_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.avm_read       = avm_read_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_byteenable = '1;
  assign bus.fifo_wr_en     = fifo_wr_en_q;
  assign bus.fifo_data      = fifo_data_q;
  assign frame_start_o      = frame_start_q;
  assign frame_done_o       = frame_done_q;
  assign busy_o             = (state_q != IDLE);
endmodule

// File: tb/tb_frame_reader_master.sv
// tb/tb_frame_reader_master.sv - self-checking bench for frame_reader_master
module tb_frame_reader_master;
  localparam int AW = 30, DW = 32, WPF = 8, MP = 4, DEPTH = 16, LW = 10, STRIDE = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          frame_start, frame_done, busy;

  frame_reader_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEVEL_W(LW)) bus ();

  frame_reader_master #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_FRAME(WPF), .ADDR_STRIDE(STRIDE),
    .MAX_PENDING(MP), .FIFO_DEPTH(DEPTH), .LEVEL_W(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .frame_base_i(frame_base),
    .bus(bus), .frame_start_o(frame_start), .frame_done_o(frame_done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [DW-1:0] data; bit live; } rd_t;

  int tests = 0, fails = 0, cyc = 0;
  // slave model
  rd_t sq[$];
  int lat = 2, wait_mode = 0, wait_left = 0, last_due = 0;
  // behavioural reference
  bit m_active = 0, m_exp_wr = 0, prev_rw = 0, level_hold = 0;
  int m_issued = 0, m_wcount = 0, live_out = 0, max_out = 0;
  logic [AW-1:0] m_base = '0, prev_addr = '0;
  // per-phase statistics from DUT outputs
  int n_wr = 0;
  int acc_cyc[$], starts[$], dones[$];
  logic [AW-1:0] acc_addr[$];

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return {2'b00, a} ^ 32'hC3C3_0000 ^ {a[7:0], 24'h0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    n_wr = 0; max_out = 0;
    acc_cyc.delete(); acc_addr.delete(); starts.delete(); dones.delete();
  endtask

  task automatic tick();
    bit in_en, in_rst, exp_done, exp_start, wt, rdv, live_ret, acc;
    logic [AW-1:0] in_base, wa;
    logic [DW-1:0] rdata;
    rd_t r;
    in_en = enable; in_rst = rst; in_base = frame_base;
    @(negedge clk);
    cyc++;
    if (bus.fifo_wr_en === 1'b1) n_wr++;
    if (frame_start === 1'b1) starts.push_back(cyc);
    if (frame_done === 1'b1) dones.push_back(cyc);

    if (in_rst) begin
      for (int i = 0; i < sq.size(); i++) sq[i].live = 1'b0;
      m_active = 0; m_issued = 0; m_wcount = 0; m_exp_wr = 0; prev_rw = 0; live_out = 0;
      check("rst_avm_read", bus.avm_read, 0);
      check("rst_avm_address", bus.avm_address, 0);
      check("rst_fifo_wr_en", bus.fifo_wr_en, 0);
      check("rst_fifo_data", bus.fifo_data, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_busy", busy, 0);
      check("rst_byteenable", bus.avm_byteenable, 4'hF);
    end else begin
      check("fifo_wr_en", bus.fifo_wr_en, m_exp_wr);
      exp_done = 0;
      if (m_exp_wr) begin
        wa = m_base + AW'(m_wcount * STRIDE);
        check("fifo_data", bus.fifo_data, dat(wa));
        m_wcount++;
        if (m_wcount == WPF) begin exp_done = 1; m_wcount = 0; end
      end
      exp_start = 0;
      if (exp_done) begin
        if (in_en) exp_start = 1; else m_active = 0;
      end else if (!m_active && in_en) begin
        exp_start = 1; m_active = 1;
      end
      if (exp_start) begin m_base = in_base; m_issued = 0; end
      check("frame_done", frame_done, exp_done);
      check("frame_start", frame_start, exp_start);
      check("busy", busy, m_active);
      check("byteenable", bus.avm_byteenable, 4'hF);
      if (exp_start) check("read_after_start", bus.avm_read, 0);
      if (prev_rw) begin
        check("stall_read_held", bus.avm_read, 1);
        check("stall_addr_held", bus.avm_address, prev_addr);
      end
      if (!m_active || m_issued >= WPF) check("no_extra_read", bus.avm_read, 0);
      if (bus.avm_read === 1'b1) begin
        wa = m_base + AW'(m_issued * STRIDE);
        check("avm_address", bus.avm_address, wa);
      end
    end

    // slave: stall decision, in-order data return
    wt = 0;
    if (bus.avm_read === 1'b1) begin
      if (wait_mode == 1) wt = ($urandom_range(3) == 0);
      else if (wait_mode == 2 && m_issued == 1 && wait_left > 0) begin wt = 1; wait_left--; end
    end
    rdv = 0; live_ret = 0; rdata = $urandom;
    if (sq.size() > 0 && sq[0].due <= cyc) begin
      r = sq.pop_front(); rdv = 1; rdata = r.data; live_ret = r.live;
    end
    bus.avm_waitrequest   = wt;
    bus.avm_readdatavalid = rdv;
    bus.avm_readdata      = rdata;

    // reference bookkeeping for the next cycle
    acc = (bus.avm_read === 1'b1) && !wt;
    prev_rw = (bus.avm_read === 1'b1) && wt;
    prev_addr = bus.avm_address;
    m_exp_wr = rdv && live_ret;
    if (rdv && live_ret) live_out--;
    if (acc) begin
      m_issued++; live_out++;
      r.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = r.due;
      r.data = dat(bus.avm_address);
      r.live = 1'b1;
      sq.push_back(r);
      acc_cyc.push_back(cyc); acc_addr.push_back(bus.avm_address);
      check("pending_limit", live_out <= MP, 1);
      if (level_hold) check("fifo_credit", live_out + int'(bus.fifo_level) <= DEPTH - 1, 1);
    end
    if (live_out > max_out) max_out = live_out;
  endtask

  task automatic run_until(input int target, input int budget, input bit drop_en);
    int n = 0;
    while (dones.size() < target && n < budget) begin
      tick(); n++;
      if (drop_en && starts.size() >= 2) enable = 1'b0;
    end
    check("frame_done_seen", dones.size() >= target, 1);
  endtask

  task automatic start_frame(input logic [AW-1:0] base, output int en_cyc);
    frame_base = base; enable = 1'b1; en_cyc = cyc;
    tick();
    enable = 1'b0;
  endtask

  initial begin
    int en_cyc, n;
    bus.avm_waitrequest = 1'b0; bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata = '0; bus.fifo_level = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // zero-wait slave, latency 2: eight back-to-back reads
    clear_stats(); lat = 2; wait_mode = 0;
    start_frame(30'h100, en_cyc);
    run_until(1, 100, 0);
    check("t1_start_lat", starts[0], en_cyc + 1);
    check("t1_first_read", acc_cyc[0], starts[0] + 1);
    check("t1_back_to_back", acc_cyc[7] - acc_cyc[0], 7);
    check("t1_done_cycle", dones[0], acc_cyc[0] + 10);
    check("t1_writes", n_wr, 8);
    check("t1_last_addr", acc_addr[7], 30'h107);
    repeat (3) tick();

    // latency 6: pending cap of 4, resume on first return
    clear_stats(); lat = 6;
    start_frame(30'h100, en_cyc);
    run_until(1, 200, 0);
    check("t2_max_pending", max_out, 4);
    check("t2_fourth_acc", acc_cyc[3], acc_cyc[0] + 3);
    check("t2_resume", acc_cyc[4], acc_cyc[0] + 7);
    repeat (8) tick();

    // 3-cycle stall on the second request
    clear_stats(); lat = 2; wait_mode = 2; wait_left = 3;
    start_frame(30'h100, en_cyc);
    run_until(1, 100, 0);
    check("t3_stall_accept", acc_cyc[1], acc_cyc[0] + 4);
    check("t3_next_accept", acc_cyc[2], acc_cyc[1] + 1);
    check("t3_second_addr", acc_addr[1], 30'h101);
    wait_mode = 0;
    repeat (3) tick();

    // FIFO nearly full: at most two in flight, then release
    clear_stats(); level_hold = 1; bus.fifo_level = LW'(13);
    start_frame(30'h100, en_cyc);
    repeat (10) tick();
    check("t4_max_inflight", max_out, 2);
    level_hold = 0; bus.fifo_level = '0;
    run_until(1, 100, 0);
    check("t4_writes", n_wr, 8);
    repeat (3) tick();

    // enable held, base changed mid-frame
    clear_stats(); frame_base = 30'h100; enable = 1'b1;
    repeat (5) tick();
    frame_base = 30'h200;
    run_until(2, 200, 1);
    enable = 1'b0;
    check("t5_frame1_last", acc_addr[7], 30'h107);
    check("t5_frame2_first", acc_addr[8], 30'h200);
    check("t5_frame2_last", acc_addr[15], 30'h207);
    check("t5_start_eq_done", starts[1], dones[0]);
    repeat (4) tick();
    check("t5_idle", busy, 0);

    // reset with reads outstanding
    clear_stats(); lat = 6;
    start_frame(30'h300, en_cyc);
    n = 0;
    while (live_out < 3 && n < 50) begin tick(); n++; end
    check("t6_outstanding", live_out, 3);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    clear_stats();
    repeat (12) tick();
    check("t6_no_stale_write", n_wr, 0);
    start_frame(30'h300, en_cyc);
    run_until(1, 200, 0);
    check("t6_restart_addr", acc_addr[0], 30'h300);
    check("t6_writes", n_wr, 8);

    // randomized traffic
    clear_stats(); wait_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) frame_base = AW'($urandom);
      if ($urandom_range(15) == 0) bus.fifo_level = LW'($urandom_range(12));
      lat = $urandom_range(6, 1);
      tick();
    end
    enable = 1'b0; bus.fifo_level = '0;
    n = 0;
    while ((busy !== 1'b0 || sq.size() != 0) && n < 300) begin tick(); n++; end
    check("rand_drained", busy, 0);
    check("rand_frames", dones.size() > 10, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
